div_16bit_seq: RTL and testbench
================================

Name: div_16bit_seq

Overview:
- Iterative 16-bit restoring divider for the Execute stage.
- Inverse operation of the single-cycle adder/reduction datapath: uses repeated shift-and-subtract instead of add.
- Produces quotient and remainder at a rate of one bit per cycle.
- Sits beside the ALU. Stall logic holds the pipeline from the start pulse until done.

Parameters:
- WIDTH, 16, operand/result width in bits; also the iteration count.
- CNT_W, 5, width of the iteration counter; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- dividend  input  WIDTH  numerator; captured when start is accepted.
- divisor  input  WIDTH  denominator; captured when start is accepted.
- busy  output  1  high while iterating; drives the Execute stall.
- done  output  1  one-cycle pulse when the result becomes valid.
- div_zero  output  1  set with done when the captured divisor was 0.
- quotient  output  WIDTH  result quotient; held until the next accepted start.
- remainder  output  WIDTH  result remainder; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, div_zero = 0; quotient, remainder, counter and internal registers = 0.
- States: IDLE, BUSY, DONE.
- IDLE, start=1, divisor!=0 -> BUSY.
  - Capture operands.
  - Partial remainder = 0; quotient shift register = dividend; counter = WIDTH.
- IDLE, start=1, divisor==0 -> DONE.
  - quotient = all ones; remainder = dividend; div_zero = 1.
  - Latency is 1 edge.
- BUSY, per edge:
  - Shift {rem, q} left by 1.
  - Trial = rem - divisor, computed WIDTH+1 bits wide so no carry is lost.
  - If trial is non-negative: rem = trial, q[0] = 1. Otherwise restore, q[0] = 0.
  - Counter decrements.
  - When counter reaches 1 on an edge, that edge performs the last iteration and enters DONE.
- Latency: start sampled at edge N -> done high during the cycle following edge N+WIDTH (16 edges for the default). busy is high for exactly WIDTH cycles.
- DONE:
  - done = 1 for exactly one cycle. quotient/remainder are valid and stay stable.
  - Next edge -> IDLE, unless start=1, which is accepted exactly as in IDLE (back-to-back operation, no bubble).
- start while BUSY: ignored. No queueing, no error.
- Operand inputs may change freely after acceptance; only the captured copies are used.
- div_zero stays set until the next accepted start, then clears.
- done never asserts without a preceding accepted start.
- Reset mid-BUSY aborts the operation. No done is produced.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined (two's-complement division, truncating toward zero):
  - At acceptance, both operands are converted to magnitude and the sign flags are registered.
  - On entering DONE, the quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
  - -32768 / -1 gives quotient 0x8000 (wraps), remainder 0.
  - Divide by zero behaves as in unsigned mode.
  - Latency is unchanged.
- Undefined: unsigned division only; no sign logic is synthesized.

Test Plan:
- Reset mid-operation: reset asserted during BUSY with dividend 100, divisor 7 -> immediately IDLE, all outputs 0, no done pulse. Next start with 100/7 -> quotient 14, remainder 2.
- Basic unsigned: 1000 / 7 -> done 16 cycles after start; quotient 142, remainder 6; busy high for exactly 16 cycles.
- Boundary operands:
  - 0xFFFF / 1 -> quotient 0xFFFF, remainder 0.
  - 5 / 9 -> quotient 0, remainder 5.
  - 0xFFFF / 0xFFFF -> quotient 1, remainder 0.
- Divide by zero: 1234 / 0 -> done 1 cycle after start; quotient 0xFFFF, remainder 1234, div_zero 1. The next normal divide clears div_zero.
- Handshake:
  - start pulses during BUSY are ignored; the result matches the first operands.
  - start held in the DONE cycle with 50/5 -> second result (quotient 10, remainder 0) arrives 16 cycles later, with no idle cycle.
- SIGNED_DIV_EN defined:
  - -7 / 2 -> quotient -3 (0xFFFD), remainder -1 (0xFFFF).
  - 7 / -2 -> quotient 0xFFFD, remainder 1.
  - 0x8000 / 0xFFFF -> quotient 0x8000, remainder 0.

Source files
------------

// File: rtl/div_16bit_seq.sv
// Iterative restoring divider, one quotient bit per cycle, beside the ALU.
// Define SIGNED_DIV_EN for two's-complement division truncating toward zero.
module div_16bit_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] rem_res;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign accept = start && (state == IDLE || state == DONE);

  // Shifted partial remainder can exceed WIDTH bits when divisor > 2^(W-1)
  assign sh       = {rem, q[WIDTH-1]};
  assign trial    = sh - {1'b0, dvs};
  assign q_next   = {q[WIDTH-2:0], ~trial[WIDTH]};
  assign rem_next = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;

  assign a_mag   = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag   = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_res   = neg_q ? -q_next : q_next;
  assign rem_res = neg_r ? -rem_next : rem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign a_mag   = dividend;
  assign b_mag   = divisor;
  assign q_res   = q_next;
  assign rem_res = rem_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      rem       <= '0;
      q         <= '0;
      dvs       <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (divisor == '0) begin
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          div_zero  <= 1'b1;
          quotient  <= '1;
          remainder <= dividend;
        end else begin
          state    <= BUSY;
          busy     <= 1'b1;
          div_zero <= 1'b0;
          rem      <= '0;
          q        <= a_mag;
          dvs      <= b_mag;
          cnt      <= CNT_INIT;
        end
      end else begin
        unique case (state)
          BUSY: begin
            rem <= rem_next;
            q   <= q_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= q_res;
              remainder <= rem_res;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_16bit_seq.sv
// Directed self-checking bench for div_16bit_seq.
// Signed vectors run only when SIGNED_DIV_EN is defined.
module tb_div_16bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [15:0] quotient;
  logic [15:0] remainder;

  int checks = 0;
  int failures = 0;

  div_16bit_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  // Returns at the negedge right after the accepting edge.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_zero, quotient, remainder} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got b=%b d=%b z=%b q=%h r=%h exp all 0",
               busy, done, div_zero, quotient, remainder);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, bcnt;
    do_start(16'd1000, 16'd7);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 16) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=16", cyc);
    end
    checks++;
    if (bcnt !== 16) begin
      failures++;
      $display("FAIL basic_busy_cycles got=%0d exp=16", bcnt);
    end
    checks++;
    if (quotient !== 16'd142 || remainder !== 16'd6 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got q=%0d r=%0d z=%b exp q=142 r=6 z=0",
               quotient, remainder, div_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quotient !== 16'd142 || remainder !== 16'd6) begin
      failures++;
      $display("FAIL basic_hold got d=%b q=%0d r=%0d exp d=0 q=142 r=6",
               done, quotient, remainder);
    end
  endtask

  task automatic test_boundary;
    logic [15:0] va [3] = '{16'hFFFF, 16'd5, 16'hFFFF};
    logic [15:0] vb [3] = '{16'd1,    16'd9, 16'hFFFF};
    logic [15:0] eq [3] = '{16'hFFFF, 16'd0, 16'd1};
    logic [15:0] er [3] = '{16'd0,    16'd5, 16'd0};
    int cyc, bcnt;
    for (int i = 0; i < 3; i++) begin
      do_start(va[i], vb[i]);
      wait_done(cyc, bcnt);
      checks++;
      if (cyc !== 16 || quotient !== eq[i] || remainder !== er[i]) begin
        failures++;
        $display("FAIL boundary_%0d got cyc=%0d q=%h r=%h exp cyc=16 q=%h r=%h",
                 i, cyc, quotient, remainder, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int cyc, bcnt;
    do_start(16'd1234, 16'd0);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 0 || bcnt !== 0) begin
      failures++;
      $display("FAIL divzero_latency got cyc=%0d busy=%0d exp 0 0", cyc, bcnt);
    end
    checks++;
    if (quotient !== 16'hFFFF || remainder !== 16'd1234 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL divzero_result got q=%h r=%0d z=%b exp q=ffff r=1234 z=1",
               quotient, remainder, div_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL divzero_hold got d=%b z=%b exp d=0 z=1", done, div_zero);
    end
    do_start(16'd20, 16'd4);
    checks++;
    if (div_zero !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL divzero_clear got z=%b b=%b exp z=0 b=1", div_zero, busy);
    end
    wait_done(cyc, bcnt);
    checks++;
    if (quotient !== 16'd5 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL divzero_next got q=%0d r=%0d exp q=5 r=0",
               quotient, remainder);
    end
  endtask

  task automatic test_ignore_busy;
    int cyc, bcnt;
    do_start(16'd100, 16'd7);
    repeat (3) @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (cyc + 4 !== 16 || quotient !== 16'd14 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL ignore_busy got cyc=%0d q=%0d r=%0d exp cyc=16 q=14 r=2",
               cyc + 4, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt;
    do_start(16'd200, 16'd3);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 16 || quotient !== 16'd66 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL b2b_first got cyc=%0d q=%0d r=%0d exp cyc=16 q=66 r=2",
               cyc, quotient, remainder);
    end
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_bubble got b=%b d=%b exp b=1 d=0", busy, done);
    end
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 16 || quotient !== 16'd10 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL b2b_second got cyc=%0d q=%0d r=%0d exp cyc=16 q=10 r=0",
               cyc, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, bcnt, dcnt;
    do_start(16'd100, 16'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_zero, quotient, remainder} !== 35'd0) begin
      failures++;
      $display("FAIL reset_mid got b=%b d=%b z=%b q=%h r=%h exp all 0",
               busy, done, div_zero, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got=%0d exp=0", dcnt);
    end
    do_start(16'd100, 16'd7);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 16 || quotient !== 16'd14 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL reset_mid_rerun got cyc=%0d q=%0d r=%0d exp cyc=16 q=14 r=2",
               cyc, quotient, remainder);
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed;
    logic [15:0] va [3] = '{16'hFFF9, 16'h0007, 16'h8000};
    logic [15:0] vb [3] = '{16'h0002, 16'hFFFE, 16'hFFFF};
    logic [15:0] eq [3] = '{16'hFFFD, 16'hFFFD, 16'h8000};
    logic [15:0] er [3] = '{16'hFFFF, 16'h0001, 16'h0000};
    int cyc, bcnt;
    for (int i = 0; i < 3; i++) begin
      do_start(va[i], vb[i]);
      wait_done(cyc, bcnt);
      checks++;
      if (cyc !== 16 || quotient !== eq[i] || remainder !== er[i]) begin
        failures++;
        $display("FAIL signed_%0d got cyc=%0d q=%h r=%h exp cyc=16 q=%h r=%h",
                 i, cyc, quotient, remainder, eq[i], er[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
